control_unit: RTL and testbench



---
 rtl/control_unit_pkg.sv | 67 ++++++
 rtl/control_unit_if.sv | 54 +++++
 rtl/control_unit_ctrl_decoder.sv | 58 +++++
 rtl/control_unit.sv | 69 ++++++
 tb/tb_control_unit.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/control_unit_pkg.sv
// control_unit_pkg: shared definitions for the decode-stage control path.
//   - ALU operation codes driven onto alu_op
//   - memory access size codes
//   - instruction class values of instr[27:25]
//   - packed control bundle carried ID -> EX, and the EX -> MEM subset
package control_unit_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_EOR = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_RSB = 4'b0011;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_ADC = 4'b0101;
    localparam logic [3:0] ALU_SBC = 4'b0110;
    localparam logic [3:0] ALU_RSC = 4'b0111;
    localparam logic [3:0] ALU_TST = 4'b1000;
    localparam logic [3:0] ALU_TEQ = 4'b1001;
    localparam logic [3:0] ALU_CMP = 4'b1010;
    localparam logic [3:0] ALU_CMN = 4'b1011;
    localparam logic [3:0] ALU_ORR = 4'b1100;
    localparam logic [3:0] ALU_MOV = 4'b1101;
    localparam logic [3:0] ALU_BIC = 4'b1110;
    localparam logic [3:0] ALU_MVN = 4'b1111;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        CLS_DP_REG = 3'b000,
        CLS_DP_IMM = 3'b001,
        CLS_LS_IMM = 3'b010,
        CLS_LS_REG = 3'b011,
        CLS_BRANCH = 3'b101
    } instr_class_e;

    // Decoded control bundle entering ID/EX.
    typedef struct packed {
        logic       shift_imm;
        logic [3:0] alu_op;
        logic [1:0] size;
        logic       mem_en;
        logic       rw;
        logic       load;
        logic       s;
        logic       rf_en;
    } ctrl_t;

    // Subset that continues from EX into EX/MEM.
    typedef struct packed {
        logic [1:0] size;
        logic       mem_en;
        logic       rw;
        logic       load;
        logic       rf_en;
    } mem_ctrl_t;

    function automatic mem_ctrl_t to_mem(input ctrl_t c);
        mem_ctrl_t m;
        m.size   = c.size;
        m.mem_en = c.mem_en;
        m.rw     = c.rw;
        m.load   = c.load;
        m.rf_en  = c.rf_en;
        return m;
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: instruction/bubble inputs and all decode, ID/EX and
// EX/MEM control outputs of control_unit.
//   master: drives instr, cu_nop; observes every control output
//   slave : the control unit itself
interface control_unit_if;

    logic [31:0] instr;
    logic        cu_nop;

    logic        id_shift_imm;
    logic [3:0]  id_alu_op;
    logic [1:0]  id_size;
    logic        id_mem_en;
    logic        id_rw;
    logic        id_load;
    logic        id_s;
    logic        id_rf_en;
    logic        id_b_instr;
    logic        id_b_l;

    logic        ex_shift_imm;
    logic [3:0]  ex_alu_op;
    logic [1:0]  ex_size;
    logic        ex_mem_en;
    logic        ex_rw;
    logic        ex_load;
    logic        ex_s;
    logic        ex_rf_en;

    logic [1:0]  mem_size;
    logic        mem_mem_en;
    logic        mem_rw;
    logic        mem_load;
    logic        mem_rf_en;

    modport master (
        output instr, cu_nop,
        input  id_shift_imm, id_alu_op, id_size, id_mem_en, id_rw, id_load,
               id_s, id_rf_en, id_b_instr, id_b_l,
        input  ex_shift_imm, ex_alu_op, ex_size, ex_mem_en, ex_rw, ex_load,
               ex_s, ex_rf_en,
        input  mem_size, mem_mem_en, mem_rw, mem_load, mem_rf_en
    );

    modport slave (
        input  instr, cu_nop,
        output id_shift_imm, id_alu_op, id_size, id_mem_en, id_rw, id_load,
               id_s, id_rf_en, id_b_instr, id_b_l,
        output ex_shift_imm, ex_alu_op, ex_size, ex_mem_en, ex_rw, ex_load,
               ex_s, ex_rf_en,
        output mem_size, mem_mem_en, mem_rw, mem_load, mem_rf_en
    );

endinterface

// File: rtl/control_unit_ctrl_decoder.sv
// control_unit_ctrl_decoder: combinational decode of a 32-bit ARM-subset
// instruction into the control bundle plus branch flags.
//   instr_i    : instruction from IF/ID (condition field ignored)
//   ctrl_o     : decoded control bundle
//   b_instr_o  : instruction is a branch
//   b_l_o      : branch with link
module control_unit_ctrl_decoder
    import control_unit_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic        b_instr_o,
    output logic        b_l_o
);

    logic [2:0] cls;
    logic       unused_bits;

    assign cls         = instr_i[27:25];
    // Condition and register/offset fields are handled elsewhere.
    assign unused_bits = ^{instr_i[31:28], instr_i[19:0]};

    always_comb begin
        ctrl_o    = '0;
        b_instr_o = 1'b0;
        b_l_o     = 1'b0;
        // The all-zero word is the pipeline NOP even though it sits in the
        // data-processing class.
        if (instr_i != '0) begin
            case (cls)
                CLS_DP_REG, CLS_DP_IMM: begin
                    ctrl_o.shift_imm = instr_i[25];
                    ctrl_o.alu_op    = instr_i[24:21];
                    ctrl_o.s         = instr_i[20];
                    // TST/TEQ/CMP/CMN (10xx) only set flags.
                    ctrl_o.rf_en     = (instr_i[24:23] != 2'b10);
                end
                CLS_LS_IMM, CLS_LS_REG: begin
                    ctrl_o.shift_imm = ~instr_i[25];
                    ctrl_o.alu_op    = instr_i[23] ? ALU_ADD : ALU_SUB;
                    ctrl_o.size      = instr_i[22] ? SIZE_BYTE : SIZE_WORD;
                    ctrl_o.mem_en    = 1'b1;
                    ctrl_o.rw        = ~instr_i[20];
                    ctrl_o.load      = instr_i[20];
                    ctrl_o.rf_en     = instr_i[20];
                end
                CLS_BRANCH: begin
                    b_instr_o        = 1'b1;
                    b_l_o            = instr_i[24];
                    ctrl_o.rf_en     = instr_i[24];
                    ctrl_o.alu_op    = ALU_ADD;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: decode-stage control path. Decodes instr combinationally,
// registers the full control bundle into ID/EX and the memory/write-back
// subset into EX/MEM.
//   CLK : rising-edge clock for both pipeline registers
//   CLR : synchronous active-high clear of both registers
//   bus : control_unit_if.slave (instr, cu_nop in; id_*, ex_*, mem_* out)
module control_unit
    import control_unit_pkg::*;
(
    input  logic            CLK,
    input  logic            CLR,
    control_unit_if.slave   bus
);

    ctrl_t     dec;
    logic      b_instr;
    logic      b_l;

    ctrl_t     id_ex_d, id_ex_q;
    mem_ctrl_t ex_mem_d, ex_mem_q;

    control_unit_ctrl_decoder u_ctrl_decoder (
        .instr_i   (bus.instr),
        .ctrl_o    (dec),
        .b_instr_o (b_instr),
        .b_l_o     (b_l)
    );

    // Bubble only affects what enters ID/EX, never the id_* view.
    assign id_ex_d  = bus.cu_nop ? '0 : dec;
    assign ex_mem_d = to_mem(id_ex_q);

    always_ff @(posedge CLK) begin
        if (CLR) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
        end
    end

    assign bus.id_shift_imm = dec.shift_imm;
    assign bus.id_alu_op    = dec.alu_op;
    assign bus.id_size      = dec.size;
    assign bus.id_mem_en    = dec.mem_en;
    assign bus.id_rw        = dec.rw;
    assign bus.id_load      = dec.load;
    assign bus.id_s         = dec.s;
    assign bus.id_rf_en     = dec.rf_en;
    assign bus.id_b_instr   = b_instr;
    assign bus.id_b_l       = b_l;

    assign bus.ex_shift_imm = id_ex_q.shift_imm;
    assign bus.ex_alu_op    = id_ex_q.alu_op;
    assign bus.ex_size      = id_ex_q.size;
    assign bus.ex_mem_en    = id_ex_q.mem_en;
    assign bus.ex_rw        = id_ex_q.rw;
    assign bus.ex_load      = id_ex_q.load;
    assign bus.ex_s         = id_ex_q.s;
    assign bus.ex_rf_en     = id_ex_q.rf_en;

    assign bus.mem_size     = ex_mem_q.size;
    assign bus.mem_mem_en   = ex_mem_q.mem_en;
    assign bus.mem_rw       = ex_mem_q.rw;
    assign bus.mem_load     = ex_mem_q.load;
    assign bus.mem_rf_en    = ex_mem_q.rf_en;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized + directed stimulus for control_unit with a
// queue-based scoreboard. Expected id bundles and expected post-edge
// register contents are queued by the stimulus; two monitors pop/compare.
module tb_control_unit;

    logic CLK;
    logic CLR;

    control_unit_if bus ();

    control_unit dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int unsigned errors = 0;
    int unsigned checks = 0;
    bit          done   = 1'b0;

    // Expected id view: {shift_imm, alu_op[3:0], size[1:0], mem_en, rw,
    // load, s, rf_en, b_instr, b_l}
    logic [13:0] idq[$];
    logic [31:0] idq_instr[$];
    // Expected registers after the next edge: {ex[11:0], mem[5:0]}
    logic [17:0] regq[$];

    logic [11:0] model_ex;
    logic [5:0]  model_mem;

    // Reference decode, straight from the instruction-class rules.
    function automatic logic [13:0] ref_decode(input logic [31:0] ins);
        logic       sh, mem_en, rw, ld, s, rf, b, bl;
        logic [3:0] alu;
        logic [1:0] sz;
        int         opcode;
        sh = 0; mem_en = 0; rw = 0; ld = 0; s = 0; rf = 0; b = 0; bl = 0;
        alu = 4'd0; sz = 2'd0;
        opcode = int'(ins[24:21]);
        if (ins == 32'd0) begin
            // NOP
        end else if (ins[27:26] == 2'b00) begin
            sh  = ins[25];
            alu = ins[24:21];
            s   = ins[20];
            rf  = !(opcode >= 8 && opcode <= 11);
        end else if (ins[27:26] == 2'b01) begin
            sh     = !ins[25];
            alu    = ins[23] ? 4'd4 : 4'd2;
            sz     = ins[22] ? 2'd0 : 2'd2;
            mem_en = 1;
            rw     = !ins[20];
            ld     = ins[20];
            rf     = ins[20];
        end else if (ins[27:25] == 3'b101) begin
            b   = 1;
            bl  = ins[24];
            rf  = ins[24];
            alu = 4'd4;
        end
        return {sh, alu, sz, mem_en, rw, ld, s, rf, b, bl};
    endfunction

    task automatic drive(input logic clr, input logic nop, input logic [31:0] ins);
        logic [13:0] d;
        logic [11:0] next_ex;
        logic [5:0]  next_mem;
        @(negedge CLK);
        CLR        = clr;
        bus.cu_nop = nop;
        bus.instr  = ins;
        d = ref_decode(ins);
        idq.push_back(d);
        idq_instr.push_back(ins);
        next_ex  = (clr || nop) ? 12'd0 : d[13:2];
        // mem keeps size, mem_en, rw, load, rf_en of the old ex value
        next_mem = clr ? 6'd0 : {model_ex[6:2], model_ex[0]};
        model_ex  = next_ex;
        model_mem = next_mem;
        regq.push_back({next_ex, next_mem});
    endtask

    // Monitor for the combinational decode.
    initial begin : mon_id
        logic [13:0] got, exp;
        logic [31:0] ins;
        while (!done) begin
            @(negedge CLK);
            #2;
            if (idq.size() != 0) begin
                exp = idq.pop_front();
                ins = idq_instr.pop_front();
                got = {bus.id_shift_imm, bus.id_alu_op, bus.id_size, bus.id_mem_en,
                       bus.id_rw, bus.id_load, bus.id_s, bus.id_rf_en,
                       bus.id_b_instr, bus.id_b_l};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL id_decode instr=%h got=%b exp=%b", ins, got, exp);
                end
            end
        end
    end

    // Monitor for the ID/EX and EX/MEM registers.
    initial begin : mon_reg
        logic [17:0] got, exp;
        while (!done) begin
            @(posedge CLK);
            #1;
            if (regq.size() != 0) begin
                exp = regq.pop_front();
                got = {bus.ex_shift_imm, bus.ex_alu_op, bus.ex_size, bus.ex_mem_en,
                       bus.ex_rw, bus.ex_load, bus.ex_s, bus.ex_rf_en,
                       bus.mem_size, bus.mem_mem_en, bus.mem_rw, bus.mem_load,
                       bus.mem_rf_en};
                checks++;
                if (got[17:6] !== exp[17:6]) begin
                    errors++;
                    $display("FAIL ex_regs t=%0t got=%b exp=%b", $time, got[17:6], exp[17:6]);
                end
                checks++;
                if (got[5:0] !== exp[5:0]) begin
                    errors++;
                    $display("FAIL mem_regs t=%0t got=%b exp=%b", $time, got[5:0], exp[5:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    localparam logic [31:0] I_ADD  = 32'hE0825005;
    localparam logic [31:0] I_SUBS = 32'hE2533001;
    localparam logic [31:0] I_CMP  = 32'hE1530004;
    localparam logic [31:0] I_STRB = 32'hE5C15003;
    localparam logic [31:0] I_LDR  = 32'hE5915000;
    localparam logic [31:0] I_BNE  = 32'h1AFFFFFD;
    localparam logic [31:0] I_BLLE = 32'hDB000001;

    initial begin : stim
        logic [31:0] r;
        int unsigned k;
        CLR        = 1'b1;
        bus.cu_nop = 1'b0;
        bus.instr  = 32'd0;
        model_ex   = '0;
        model_mem  = '0;

        // Reset with a live instruction present.
        drive(1'b1, 1'b0, I_ADD);
        drive(1'b0, 1'b0, I_ADD);
        drive(1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, I_SUBS);
        drive(1'b0, 1'b0, I_CMP);
        drive(1'b0, 1'b0, I_STRB);
        drive(1'b0, 1'b0, I_LDR);
        drive(1'b0, 1'b0, I_BNE);
        drive(1'b0, 1'b0, I_BLLE);
        drive(1'b0, 1'b0, 32'd0);
        // Stream with a bubble on the STRB cycle.
        drive(1'b0, 1'b0, I_ADD);
        drive(1'b0, 1'b0, I_SUBS);
        drive(1'b0, 1'b0, I_BNE);
        drive(1'b0, 1'b1, I_STRB);
        drive(1'b0, 1'b0, I_BLLE);
        drive(1'b0, 1'b0, 32'd0);
        // Clear mid-stream, also together with a bubble.
        drive(1'b0, 1'b0, I_LDR);
        drive(1'b0, 1'b0, I_SUBS);
        drive(1'b1, 1'b0, I_BLLE);
        drive(1'b0, 1'b0, I_LDR);
        drive(1'b0, 1'b0, I_ADD);
        drive(1'b1, 1'b1, I_STRB);
        drive(1'b0, 1'b0, I_STRB);

        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            k = $urandom_range(0, 7);
            case (k)
                0:       r = 32'd0;
                1, 2:    r[27:26] = 2'b00;
                3, 4:    r[27:26] = 2'b01;
                5:       r[27:25] = 3'b101;
                default: ;
            endcase
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) == 0), r);
        end

        repeat (3) @(negedge CLK);
        done = 1'b1;
        checks++;
        if (idq.size() != 0 || regq.size() != 0) begin
            errors++;
            $display("FAIL queues_drained got=%0d/%0d exp=0/0", idq.size(), regq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
